// File: rtl/seg7_pkg.sv
// Shared 7-segment types, blank pattern and the hex glyph table.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_BLANK = 7'h7F;

    // {CA,CB,CC,CD,CE,CF,CG}, active-low
    localparam seg7_t SEG7_GLYPHS [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic seg7_t hex_to_seg7(input logic [3:0] nibble);
        return SEG7_GLYPHS[nibble];
    endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational hex nibble to active-low 7-segment glyph.
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg7_t      o_seg
);

    assign o_seg = hex_to_seg7(i_nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with per-frame input snapshot.
// Optional LEADING_ZERO_SUPPRESS_EN darkens leading zero digits above digit 0.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    output logic [DIGITS-1:0]     an,
    output seg7_t                 seg,
    output logic                  dp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]    r_div;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_sh_dig;
    logic [DIGITS-1:0]   r_sh_dp;
    logic [DIGITS-1:0]   r_sh_blank;

    logic                w_last_div;
    logic                w_last_idx;
    logic                w_guard;
    logic                w_blank;
    logic [3:0]          w_nib;
    seg7_t               w_glyph;
    logic [DIGITS-1:0]   w_an;

    assign w_last_div = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_last_idx = (r_idx == IDX_W'(DIGITS - 1));
    assign w_guard    = (int'(r_div) < GUARD);
    assign w_nib      = r_sh_dig[{r_idx, 2'b00} +: 4];
    assign w_an       = ~(DIGITS'(1) << r_idx);

`ifdef LEADING_ZERO_SUPPRESS_EN
    logic [DIGITS-1:0] w_lz;
    logic              w_zrun;

    // Walk down from the top digit; a digit is suppressed while everything
    // at and above it is zero and it carries no decimal point.
    always_comb begin
        w_lz   = '0;
        w_zrun = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zrun  = w_zrun & (r_sh_dig[4*i +: 4] == 4'h0);
            w_lz[i] = w_zrun & ~r_sh_dp[i];
        end
    end

    assign w_blank = r_sh_blank[r_idx] | w_lz[r_idx];
`else
    assign w_blank = r_sh_blank[r_idx];
`endif

    seg7_glyph_rom u_rom (
        .i_nibble (w_nib),
        .o_seg    (w_glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= '0;
            r_idx      <= '0;
            r_sh_dig   <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '1;
            an         <= '1;
            seg        <= SEG7_BLANK;
            dp         <= 1'b1;
        end else begin
            if (w_last_div) begin
                r_div <= '0;
                r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end

            // Capture the next frame's contents only on the frame boundary.
            if (w_last_div && w_last_idx) begin
                r_sh_dig   <= digits_in;
                r_sh_dp    <= dp_in;
                r_sh_blank <= blank_in;
            end

            if (w_guard || w_blank) begin
                an  <= '1;
                seg <= SEG7_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= w_an;
                seg <= w_glyph;
                dp  <= ~r_sh_dp[r_idx];
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a frame-level model.
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int G  = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4*D-1:0] digits_in;
    logic [D-1:0]  dp_in;
    logic [D-1:0]  blank_in;
    logic [D-1:0]  an;
    logic [6:0]    seg;
    logic          dp;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .GUARD(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: cycles since reset and the frame contents being shown.
    int            t;
    logic [15:0]   m_dig;
    logic [3:0]    m_dp;
    logic [3:0]    m_blank;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, act, exp, t);
        end
    endtask

    // Predict the outputs after the next edge, advance one clock, compare.
    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         div;
        int         idx;
        bit         lit;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (rst) begin
            t       = 0;
            m_dig   = '0;
            m_dp    = '0;
            m_blank = '1;
        end else begin
            div = t % SD;
            idx = (t / SD) % D;
            lit = (div >= G) && !m_blank[idx];
`ifdef LEADING_ZERO_SUPPRESS_EN
            if (idx > 0 && (m_dig >> (4*idx)) == 0 && !m_dp[idx])
                lit = 0;
`endif
            if (lit) begin
                e_an  = 4'hF & ~(4'b0001 << idx);
                e_seg = GLYPH[(m_dig >> (4*idx)) & 16'hF];
                e_dp  = !m_dp[idx];
            end
            if (div == SD - 1 && idx == D - 1) begin
                m_dig   = digits_in;
                m_dp    = dp_in;
                m_blank = blank_in;
            end
            t++;
        end
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_in(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        digits_in = d;
        dp_in     = p;
        blank_in  = b;
    endtask

    initial begin
        t = 0;
        m_dig = '0; m_dp = '0; m_blank = '1;
        rst = 1'b1;
        set_in(16'h1234, 4'b0100, 4'b0000);
        run(3);
        rst = 1'b0;
        run(2 * D * SD);

        // Reset mid-slot, then a dark first frame again
        run(5);
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(3 * D * SD);

        // Glyph sweep on digit 0
        for (int k = 0; k < 16; k++) begin
            set_in({4'($urandom), 4'($urandom), 4'($urandom), 4'(k)}, 4'($urandom), 4'b0000);
            run(D * SD);
        end

        // Snapshot: change inputs while slot 1 is being shown
        set_in(16'h1234, 4'b0100, 4'b0000);
        run(D * SD);
        while ((t % (D * SD)) != SD + 1) step();
        digits_in = 16'h9999;
        run(2 * D * SD);

        // Blanking
        set_in(16'h1234, 4'b0000, 4'b1010);
        run(2 * D * SD);

        // Leading zero patterns
        set_in(16'h0042, 4'b0000, 4'b0000);
        run(2 * D * SD);
        set_in(16'h0000, 4'b0000, 4'b0000);
        run(2 * D * SD);
        set_in(16'h0042, 4'b0100, 4'b0000);
        run(2 * D * SD);

        // Random traffic with occasional resets
        for (int r = 0; r < 60; r++) begin
            set_in(16'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
            rst = ($urandom_range(0, 12) == 0);
            if (rst) begin
                run(1);
                rst = 1'b0;
            end
            run($urandom_range(1, 24));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
